// File: rtl/seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_ctrl_if
// Description : Data-memory handshake between the SEQ stage sequencer and the
//               data memory. The sequencer holds mem_req until mem_ack; a
//               dmem_error is only meaningful together with mem_ack.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_ctrl_if;
    logic mem_req;
    logic mem_ack;
    logic dmem_error;

    // Sequencer side
    modport master (
        output mem_req,
        input  mem_ack,
        input  dmem_error
    );

    // Memory side
    modport slave (
        input  mem_req,
        output mem_ack,
        output dmem_error
    );
endinterface
`default_nettype wire

// File: rtl/seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_ctrl
// Description : Multi-cycle stage sequencer for the Y86-64 SEQ processor.
//               Steps FETCH/DECODE/EXEC/MEM/WB/PCUPD one stage per clock,
//               skips MEM for non-memory icodes, handshakes with data memory
//               (with a bounded wait), tracks the Y86 status code and keeps
//               cycle / retired-instruction counters. Moore outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    seq_ctrl_if.master       dmem,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             cc_we,
    output logic             wb_en,
    output logic             pc_en,
    output logic             busy,
    output logic [2:0]       stat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_PAUSE  = 4'd1;
    localparam logic [3:0] ST_FETCH  = 4'd2;
    localparam logic [3:0] ST_DECODE = 4'd3;
    localparam logic [3:0] ST_EXEC   = 4'd4;
    localparam logic [3:0] ST_MEM    = 4'd5;
    localparam logic [3:0] ST_WB     = 4'd6;
    localparam logic [3:0] ST_PCUPD  = 4'd7;
    localparam logic [3:0] ST_HALT   = 4'd8;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] ICODE_HALT = 4'h0;
    localparam logic [3:0] ICODE_OPQ  = 4'h6;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;

    localparam logic [7:0]       TIMEOUT_LIM = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [2:0] stat_nxt;
    logic [3:0] icode_q;
    logic [7:0] timer;
    logic [7:0] timer_inc;
    logic       is_mem_op;
    logic       is_mem_wb;
    logic       is_reg_wb;

    // Instruction classes, decoded from the icode latched at fetch
    assign is_mem_op = (icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB});
    assign is_mem_wb = is_mem_op && (icode_q != ICODE_RMMOVQ);
    assign is_reg_wb = (icode_q inside {4'h2, 4'h3, 4'h6});
    assign timer_inc = timer + 8'd1;

    // State register; reset aborts any in-flight instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status-update decision
    always_comb begin
        state_nxt = state;
        stat_nxt  = stat;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = step_mode ? ST_PAUSE : ST_FETCH;
                end
            end
            ST_PAUSE: begin
                if (step) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Fault priority: address fault, then invalid, then halt
                if (imem_error) begin
                    state_nxt = ST_HALT;
                    stat_nxt  = STAT_ADR;
                end else if (!instr_valid) begin
                    state_nxt = ST_HALT;
                    stat_nxt  = STAT_INS;
                end else if (icode == ICODE_HALT) begin
                    state_nxt = ST_HALT;
                    stat_nxt  = STAT_HLT;
                end else begin
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_mem_op) begin
                    state_nxt = ST_MEM;
                end else if (is_reg_wb) begin
                    state_nxt = ST_WB;
                end else begin
                    state_nxt = ST_PCUPD;
                end
            end
            ST_MEM: begin
                // An ack on the last allowed cycle beats the timeout
                if (dmem.mem_ack) begin
                    if (dmem.dmem_error) begin
                        state_nxt = ST_HALT;
                        stat_nxt  = STAT_ADR;
                    end else begin
                        state_nxt = is_mem_wb ? ST_WB : ST_PCUPD;
                    end
                end else if (timer_inc == TIMEOUT_LIM) begin
                    state_nxt = ST_HALT;
                    stat_nxt  = STAT_ADR;
                end
            end
            ST_WB: begin
                state_nxt = ST_PCUPD;
            end
            ST_PCUPD: begin
                state_nxt = step_mode ? ST_PAUSE : ST_FETCH;
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state only
    always_comb begin
        fetch_en     = 1'b0;
        decode_en    = 1'b0;
        exec_en      = 1'b0;
        cc_we        = 1'b0;
        dmem.mem_req = 1'b0;
        wb_en        = 1'b0;
        pc_en        = 1'b0;
        busy         = 1'b1;
        case (state)
            ST_IDLE:   busy         = 1'b0;
            ST_HALT:   busy         = 1'b0;
            ST_FETCH:  fetch_en     = 1'b1;
            ST_DECODE: decode_en    = 1'b1;
            ST_EXEC: begin
                exec_en = 1'b1;
                cc_we   = (icode_q == ICODE_OPQ);
            end
            ST_MEM:    dmem.mem_req = 1'b1;
            ST_WB:     wb_en        = 1'b1;
            ST_PCUPD:  pc_en        = 1'b1;
            default:   busy         = 1'b1;
        endcase
    end

    // Latched icode, memory wait timer, status and performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icode_q   <= 4'h0;
            timer     <= 8'd0;
            stat      <= STAT_AOK;
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            stat <= stat_nxt;
            if (state == ST_FETCH) begin
                icode_q <= icode;
            end
            if (state == ST_EXEC) begin
                timer <= 8'd0;
            end else if ((state == ST_MEM) && !dmem.mem_ack) begin
                timer <= timer_inc;
            end
            if (busy) begin
                cycle_cnt <= cycle_cnt + CNT_ONE;
            end
            if (pc_en) begin
                instr_cnt <= instr_cnt + CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_ctrl
// Description : Self-checking bench for seq_ctrl: a table of single
//               instructions with hand-derived latencies, hand-written
//               corner sequences, and random programs checked against a
//               per-instruction stage-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_ctrl;

    localparam int TO = 15;

    localparam logic [6:0] EN_F  = 7'b1000000;
    localparam logic [6:0] EN_D  = 7'b0100000;
    localparam logic [6:0] EN_E  = 7'b0010000;
    localparam logic [6:0] EN_CC = 7'b0001000;
    localparam logic [6:0] EN_M  = 7'b0000100;
    localparam logic [6:0] EN_W  = 7'b0000010;
    localparam logic [6:0] EN_P  = 7'b0000001;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        step_mode;
    logic        step;
    logic [3:0]  icode;
    logic        instr_valid;
    logic        imem_error;
    logic        fetch_en;
    logic        decode_en;
    logic        exec_en;
    logic        cc_we;
    logic        wb_en;
    logic        pc_en;
    logic        busy;
    logic [2:0]  stat;
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
    logic [6:0]  en_now;

    seq_ctrl_if dmem();

    seq_ctrl #(.CNT_W(32), .MEM_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .step_mode   (step_mode),
        .step        (step),
        .icode       (icode),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .dmem        (dmem),
        .fetch_en    (fetch_en),
        .decode_en   (decode_en),
        .exec_en     (exec_en),
        .cc_we       (cc_we),
        .wb_en       (wb_en),
        .pc_en       (pc_en),
        .busy        (busy),
        .stat        (stat),
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
    );

    assign en_now = {fetch_en, decode_en, exec_en, cc_we, dmem.mem_req, wb_en, pc_en};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0; step = 1'b0; step_mode = 1'b0;
        icode = 4'h0; instr_valid = 1'b0; imem_error = 1'b0;
        dmem.mem_ack = 1'b0; dmem.dmem_error = 1'b0;
        tick();
        tick();
        check("reset_en", 64'(en_now), 64'd0);
        check("reset_busy_stat", 64'({busy, stat}), 64'({1'b0, 3'd1}));
        check("reset_counters", {cycle_cnt, instr_cnt}, 64'd0);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Table of single instructions with hand-derived results
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0] ic;
        logic       valid;
        logic       ierr;
        int         delay;
        logic       derr;
        int         cyc;
        int         memc;
        int         wbc;
        int         ccc;
        int         pcc;
        logic [2:0] st;
    } vec_t;

    vec_t tbl[16];

    task automatic run_vec(input vec_t v, input int idx);
        int cyc = 0, memc = 0, wbc = 0, ccc = 0, pcc = 0;
        bit done = 0;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        icode = v.ic; instr_valid = v.valid; imem_error = v.ierr;
        for (int k = 0; k < 60 && !done; k++) begin
            if (!busy) begin
                done = 1;
            end else begin
                cyc++;
                dmem.mem_ack    = dmem.mem_req && (memc == v.delay);
                dmem.dmem_error = dmem.mem_ack && v.derr;
                if (dmem.mem_req) memc++;
                if (wb_en) wbc++;
                if (cc_we) ccc++;
                if (pc_en) begin
                    pcc++;
                    done = 1;
                end
                tick();
            end
        end
        dmem.mem_ack = 1'b0; dmem.dmem_error = 1'b0;
        check($sformatf("vec%0d_done", idx), 64'(done), 64'd1);
        check($sformatf("vec%0d_cycles", idx), 64'(cyc), 64'(v.cyc));
        check($sformatf("vec%0d_memreq", idx), 64'(memc), 64'(v.memc));
        check($sformatf("vec%0d_wb_cc_pc", idx), 64'({wbc[7:0], ccc[7:0], pcc[7:0]}),
              64'({v.wbc[7:0], v.ccc[7:0], v.pcc[7:0]}));
        check($sformatf("vec%0d_stat", idx), 64'(stat), 64'(v.st));
    endtask

    // ------------------------------------------------------------------
    // Reference model: each instruction expands into its list of stages
    // ------------------------------------------------------------------
    typedef struct {
        logic       start;
        logic       sm;
        logic       step;
        logic [3:0] ic;
        logic       valid;
        logic       ierr;
        logic       ack;
        logic       derr;
        logic [6:0] en;
        logic       busy;
        logic [2:0] st;
    } rec_t;

    rec_t q[$];

    function automatic rec_t noise();
        rec_t r;
        r.start = 1'($urandom_range(0, 1));
        r.sm    = 1'($urandom_range(0, 1));
        r.step  = 1'($urandom_range(0, 1));
        r.ic    = 4'($urandom_range(0, 15));
        r.valid = 1'($urandom_range(0, 1));
        r.ierr  = 1'($urandom_range(0, 1));
        r.ack   = 1'($urandom_range(0, 1));
        r.derr  = 1'($urandom_range(0, 1));
        r.en    = 7'd0;
        r.busy  = 1'b1;
        r.st    = 3'd1;
        return r;
    endfunction

    task automatic push_stage(input logic [6:0] en);
        rec_t r = noise();
        r.en = en;
        q.push_back(r);
    endtask

    task automatic add_pause(input int n);
        rec_t r;
        for (int i = 0; i < n; i++) begin
            r = noise();
            r.step = 1'b0;
            q.push_back(r);
        end
        r = noise();
        r.step = 1'b1;
        q.push_back(r);
    endtask

    task automatic add_instr(input logic [3:0] c, input logic valid, input logic ierr,
                             input int delay, input logic derr, input logic sm_next,
                             output logic halted, output logic [2:0] code);
        rec_t r;
        int   mcyc;
        halted = 1'b0;
        code   = 3'd1;
        r = noise();
        r.en = EN_F; r.ic = c; r.valid = valid; r.ierr = ierr;
        q.push_back(r);
        if (ierr)        begin halted = 1'b1; code = 3'd3; return; end
        if (!valid)      begin halted = 1'b1; code = 3'd4; return; end
        if (c == 4'h0)   begin halted = 1'b1; code = 3'd2; return; end
        push_stage(EN_D);
        push_stage((c == 4'h6) ? (EN_E | EN_CC) : EN_E);
        if (c inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
            mcyc = (delay < TO) ? delay + 1 : TO;
            for (int m = 0; m < mcyc; m++) begin
                r = noise();
                r.en  = EN_M;
                r.ack = (m == delay);
                if (r.ack) r.derr = derr;
                q.push_back(r);
            end
            if (delay >= TO || derr) begin halted = 1'b1; code = 3'd3; return; end
            if (c != 4'h4) push_stage(EN_W);
        end else if (c inside {4'h2, 4'h3, 4'h6}) begin
            push_stage(EN_W);
        end
        r = noise();
        r.en = EN_P;
        r.sm = sm_next;
        q.push_back(r);
    endtask

    task automatic build_program();
        rec_t       r;
        logic       sm, halted, valid, ierr, derr, sm_next;
        logic [2:0] code;
        logic [3:0] c;
        int         n, delay;
        q.delete();
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            r = noise(); r.start = 1'b0; r.busy = 1'b0; q.push_back(r);
        end
        sm = 1'($urandom_range(0, 1));
        r = noise(); r.start = 1'b1; r.sm = sm; r.busy = 1'b0; q.push_back(r);
        if (sm) add_pause($urandom_range(0, 3));
        halted = 1'b0;
        code   = 3'd1;
        n = $urandom_range(1, 8);
        for (int i = 0; i < n && !halted; i++) begin
            c       = ($urandom_range(0, 99) < 5) ? 4'h0 : 4'($urandom_range(1, 11));
            valid   = ($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1;
            ierr    = ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0;
            delay   = ($urandom_range(0, 99) < 10) ? $urandom_range(13, 16) : $urandom_range(0, 4);
            derr    = ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0;
            sm_next = 1'($urandom_range(0, 1));
            add_instr(c, valid, ierr, delay, derr, sm_next, halted, code);
            if (!halted && sm_next) add_pause($urandom_range(0, 3));
        end
        if (halted) begin
            for (int i = 0; i < 3; i++) begin
                r = noise(); r.busy = 1'b0; r.st = code; q.push_back(r);
            end
        end
    endtask

    task automatic run_program(input int run);
        int exp_cyc = 0;
        int exp_ins = 0;
        rec_t r;
        do_reset();
        for (int k = 0; k < q.size(); k++) begin
            r = q[k];
            start = r.start; step_mode = r.sm; step = r.step;
            icode = r.ic; instr_valid = r.valid; imem_error = r.ierr;
            dmem.mem_ack = r.ack; dmem.dmem_error = r.derr;
            check($sformatf("rand%0d_c%0d_outputs", run, k), 64'({en_now, busy, stat}),
                  64'({r.en, r.busy, r.st}));
            check($sformatf("rand%0d_c%0d_counters", run, k), {cycle_cnt, instr_cnt},
                  {32'(exp_cyc), 32'(exp_ins)});
            exp_cyc += int'(r.busy);
            exp_ins += int'(r.en[0]);
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int pcs, pc1, pc2, fetches;

        //            ic    v  ie dly  de  cyc mem wb cc pc st
        tbl[0]  = '{4'h1, 1, 0, 0,  0,  4,  0, 0, 0, 1, 3'd1};
        tbl[1]  = '{4'h7, 1, 0, 0,  0,  4,  0, 0, 0, 1, 3'd1};
        tbl[2]  = '{4'h6, 1, 0, 0,  0,  5,  0, 1, 1, 1, 3'd1};
        tbl[3]  = '{4'h2, 1, 0, 0,  0,  5,  0, 1, 0, 1, 3'd1};
        tbl[4]  = '{4'h3, 1, 0, 0,  0,  5,  0, 1, 0, 1, 3'd1};
        tbl[5]  = '{4'h5, 1, 0, 0,  0,  6,  1, 1, 0, 1, 3'd1};
        tbl[6]  = '{4'h5, 1, 0, 3,  0,  9,  4, 1, 0, 1, 3'd1};
        tbl[7]  = '{4'h4, 1, 0, 0,  0,  5,  1, 0, 0, 1, 3'd1};
        tbl[8]  = '{4'hA, 1, 0, 1,  0,  7,  2, 1, 0, 1, 3'd1};
        tbl[9]  = '{4'h4, 1, 0, 99, 0, 18, 15, 0, 0, 0, 3'd3};
        tbl[10] = '{4'h0, 1, 0, 0,  0,  1,  0, 0, 0, 0, 3'd2};
        tbl[11] = '{4'h0, 0, 0, 0,  0,  1,  0, 0, 0, 0, 3'd4};
        tbl[12] = '{4'h1, 0, 1, 0,  0,  1,  0, 0, 0, 0, 3'd3};
        tbl[13] = '{4'h5, 1, 0, 14, 0, 20, 15, 1, 0, 1, 3'd1};
        tbl[14] = '{4'h5, 1, 0, 2,  1,  6,  3, 0, 0, 0, 3'd3};
        tbl[15] = '{4'h9, 1, 0, 0,  0,  6,  1, 1, 0, 1, 3'd1};

        for (int i = 0; i < 16; i++) begin
            run_vec(tbl[i], i);
        end

        // nop, nop, halt: pc_en on cycles 4 and 8, then HALT is sticky
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        instr_valid = 1'b1;
        pcs = 0; pc1 = 0; pc2 = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            icode = (cyc <= 8) ? 4'h1 : 4'h0;
            if (pc_en) begin
                pcs++;
                if (pcs == 1) pc1 = cyc;
                if (pcs == 2) pc2 = cyc;
            end
            tick();
        end
        check("prog_pc_cycles", 64'({pcs[7:0], pc1[7:0], pc2[7:0]}), 64'({8'd2, 8'd4, 8'd8}));
        check("prog_final", 64'({busy, stat}), 64'({1'b0, 3'd2}));
        check("prog_counters", {cycle_cnt, instr_cnt}, {32'd9, 32'd2});
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            tick();
        end
        check("halt_sticky", 64'({en_now, busy, stat}), 64'({7'd0, 1'b0, 3'd2}));

        // Reset asserted while in EXEC of an OPq takes effect immediately
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        icode = 4'h6; instr_valid = 1'b1;
        tick();
        tick();
        check("exec_opq", 64'(en_now), 64'(EN_E | EN_CC));
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'({en_now, busy, stat}), 64'({7'd0, 1'b0, 3'd1}));
        check("async_reset_counters", {cycle_cnt, instr_cnt}, 64'd0);
        tick();
        rst_n = 1'b1;

        // Step mode: one instruction per step, stray steps ignored
        do_reset();
        step_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        icode = 4'h1; instr_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            fetches = 0;
            for (int j = 0; j < 3; j++) begin
                if (fetch_en || !busy) fetches++;
                tick();
            end
            check($sformatf("step%0d_paused", s), 64'(fetches), 64'd0);
            step = 1'b1;
            tick();
            pcs = 0;
            for (int j = 0; j < 5; j++) begin
                step = (j == 1);
                if (pc_en) pcs++;
                tick();
            end
            step = 1'b0;
            check($sformatf("step%0d_one_retire", s), 64'(pcs), 64'd1);
        end
        check("step_instr_cnt", 64'(instr_cnt), 64'd3);

        // Random programs against the stage-list model
        for (int run = 0; run < 40; run++) begin
            build_program();
            run_program(run);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
